// File: rtl/sprite_fetch_arbiter.sv
// Shares the sprite ROM between the ghost and Pac-Man engines, prefetching one
// 32-pixel row per hit sprite into its line buffer during horizontal blanking.
//
// state   | meaning
// IDLE    | waiting for line_start; inputs snapshotted when it arrives
// CHECK   | row/sprite intersection test, hit flags and X latched
// FETCH_G | 32 ghost ROM reads, one per cycle
// FETCH_P | 32 Pac-Man ROM reads, addressing set by orientation
// FLUSH   | last ROM word written to the buffer
// DONE    | one-cycle completion pulse
module sprite_fetch_arbiter #(
  parameter int SPR        = 32,
  parameter int GHOST_BASE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_start,
  input  logic [8:0]  next_row,
  input  logic [9:0]  PacX,
  input  logic [8:0]  PacY,
  input  logic [9:0]  GhostX,
  input  logic [8:0]  GhostY,
  input  logic [1:0]  state,
  output logic [10:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic        lb_we,
  output logic        lb_sel,
  output logic [4:0]  lb_idx,
  output logic [11:0] lb_data,
  output logic        ghost_hit,
  output logic        pac_hit,
  output logic [9:0]  ghost_x,
  output logic [9:0]  pac_x,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  typedef enum logic [2:0] {IDLE, CHECK, FETCH_G, FETCH_P, FLUSH, DONE} fsm_t;

  fsm_t        cur_st, nxt_st;
  logic [8:0]  row_q, pac_y_q, ghost_y_q;
  logic [9:0]  pac_x_q, ghost_x_q;
  logic [1:0]  orient_q;
  logic [4:0]  cnt, cnt_n;
  logic [4:0]  dy_g, dy_p;
  logic        g_hit_c, p_hit_c;
  logic [10:0] addr_n;
  logic        issue_q, issue_sel_q;
  logic [4:0]  issue_idx_q;
  logic        issue_n, sel_n;

  // 10-bit compare so that Y+32 near the bottom of the frame cannot wrap
  assign g_hit_c = ({1'b0, row_q} >= {1'b0, ghost_y_q}) &&
                   ({1'b0, row_q} <  ({1'b0, ghost_y_q} + 10'(SPR)));
  assign p_hit_c = ({1'b0, row_q} >= {1'b0, pac_y_q}) &&
                   ({1'b0, row_q} <  ({1'b0, pac_y_q} + 10'(SPR)));

  // Only the low five bits of row - Y matter once the row is known to hit
  assign dy_g = row_q[4:0] - ghost_y_q[4:0];
  assign dy_p = row_q[4:0] - pac_y_q[4:0];

  assign lb_data = rom_data;
  assign overrun = line_start & busy;

  always_comb begin
    nxt_st = cur_st;
    cnt_n  = cnt;
    case (cur_st)
      IDLE:    if (line_start) nxt_st = CHECK;
      CHECK: begin
        cnt_n = 5'd0;
        if (g_hit_c)      nxt_st = FETCH_G;
        else if (p_hit_c) nxt_st = FETCH_P;
        else              nxt_st = DONE;
      end
      FETCH_G: begin
        cnt_n = cnt + 5'd1;
        if (cnt == 5'd31) nxt_st = pac_hit ? FETCH_P : FLUSH;
      end
      FETCH_P: begin
        cnt_n = cnt + 5'd1;
        if (cnt == 5'd31) nxt_st = FLUSH;
      end
      FLUSH:   nxt_st = DONE;
      DONE:    nxt_st = IDLE;
      default: nxt_st = IDLE;
    endcase
  end

  // Address for the cycle being entered, so rom_addr can be a plain register
  always_comb begin
    addr_n  = rom_addr;
    issue_n = 1'b0;
    sel_n   = 1'b0;
    if (nxt_st == FETCH_G) begin
      issue_n = 1'b1;
      sel_n   = 1'b1;
      addr_n  = 11'(GHOST_BASE) + {1'b0, dy_g, cnt_n};
    end else if (nxt_st == FETCH_P) begin
      issue_n = 1'b1;
      case (orient_q)
        2'b00:   addr_n = {1'b0, cnt_n, dy_p};
        2'b01:   addr_n = {1'b0, cnt_n, ~dy_p};
        2'b10:   addr_n = {1'b0, dy_p, cnt_n};
        default: addr_n = {1'b0, dy_p, ~cnt_n};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_st      <= IDLE;
      cnt         <= 5'd0;
      row_q       <= 9'd0;
      pac_y_q     <= 9'd0;
      ghost_y_q   <= 9'd0;
      pac_x_q     <= 10'd0;
      ghost_x_q   <= 10'd0;
      orient_q    <= 2'd0;
      rom_addr    <= 11'd0;
      issue_q     <= 1'b0;
      issue_sel_q <= 1'b0;
      issue_idx_q <= 5'd0;
      lb_we       <= 1'b0;
      lb_sel      <= 1'b0;
      lb_idx      <= 5'd0;
      ghost_hit   <= 1'b0;
      pac_hit     <= 1'b0;
      ghost_x     <= 10'd0;
      pac_x       <= 10'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      cur_st      <= nxt_st;
      cnt         <= cnt_n;
      rom_addr    <= addr_n;
      issue_q     <= issue_n;
      issue_sel_q <= sel_n;
      issue_idx_q <= cnt_n;
      lb_we       <= issue_q;
      lb_sel      <= issue_sel_q;
      lb_idx      <= issue_idx_q;
      busy        <= (nxt_st != IDLE);
      done        <= (nxt_st == DONE);
      if (cur_st == IDLE && line_start) begin
        row_q     <= next_row;
        pac_y_q   <= PacY;
        ghost_y_q <= GhostY;
        pac_x_q   <= PacX;
        ghost_x_q <= GhostX;
        orient_q  <= state;
      end
      if (cur_st == CHECK) begin
        ghost_hit <= g_hit_c;
        pac_hit   <= p_hit_c;
        ghost_x   <= ghost_x_q;
        pac_x     <= pac_x_q;
      end
    end
  end

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Scoreboard bench for sprite_fetch_arbiter: directed corner cases plus random
// rows, with expected buffer writes and completion derived from the sprite rules.
module tb_sprite_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_start;
  logic [8:0]  next_row;
  logic [9:0]  PacX, GhostX;
  logic [8:0]  PacY, GhostY;
  logic [1:0]  state;
  logic [10:0] rom_addr;
  logic [11:0] rom_data;
  logic        lb_we, lb_sel;
  logic [4:0]  lb_idx;
  logic [11:0] lb_data;
  logic        ghost_hit, pac_hit;
  logic [9:0]  ghost_x, pac_x;
  logic        busy, done, overrun;

  sprite_fetch_arbiter #(.SPR(32), .GHOST_BASE(1024)) dut (
    .clk(clk), .rst(rst), .line_start(line_start), .next_row(next_row),
    .PacX(PacX), .PacY(PacY), .GhostX(GhostX), .GhostY(GhostY), .state(state),
    .rom_addr(rom_addr), .rom_data(rom_data), .lb_we(lb_we), .lb_sel(lb_sel),
    .lb_idx(lb_idx), .lb_data(lb_data), .ghost_hit(ghost_hit), .pac_hit(pac_hit),
    .ghost_x(ghost_x), .pac_x(pac_x), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int sel; int idx; int addr; } wr_t;
  typedef struct { int cyc; int gh; int ph; int gx; int px; } dn_t;

  wr_t wq[$];
  dn_t dq[$];
  int  cyc = 0;
  int  compared = 0;
  int  mismatched = 0;

  // Injective word pattern so every distinct address yields distinct data
  function automatic logic [11:0] rom_f(input logic [10:0] a);
    return 12'(int'(a) * 5 + 12'h3A7);
  endfunction

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rom_data <= rom_f(rom_addr);
  end

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && lb_we) begin
      if (wq.size() == 0) begin
        chk("spurious_write", 1, 0);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("write_cycle", cyc, w.cyc);
        chk("write_sel", int'(lb_sel), w.sel);
        chk("write_idx", int'(lb_idx), w.idx);
        chk("write_data", int'(lb_data), int'(rom_f(11'(w.addr))));
      end
    end
    if (!rst && done) begin
      if (dq.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        dn_t d;
        d = dq.pop_front();
        chk("done_cycle", cyc, d.cyc);
        chk("busy_at_done", int'(busy), 1);
        chk("ghost_hit", int'(ghost_hit), d.gh);
        chk("pac_hit", int'(pac_hit), d.ph);
        chk("ghost_x", int'(ghost_x), d.gx);
        chk("pac_x", int'(pac_x), d.px);
      end
    end
  end

  function automatic int pac_addr(input int st, input int dy, input int i);
    case (st)
      0:       return i * 32 + dy;
      1:       return i * 32 + (31 - dy);
      2:       return dy * 32 + i;
      default: return dy * 32 + (31 - i);
    endcase
  endfunction

  task automatic push_exp(input int t0, input int row, input int px, input int py,
                          input int gx, input int gy, input int st);
    int gh, ph, first;
    wr_t w;
    dn_t d;
    gh = (row >= gy && row < gy + 32) ? 1 : 0;
    ph = (row >= py && row < py + 32) ? 1 : 0;
    first = t0 + 3;
    if (gh == 1) begin
      for (int i = 0; i < 32; i++) begin
        w.cyc = first + i; w.sel = 1; w.idx = i; w.addr = 1024 + (row - gy) * 32 + i;
        wq.push_back(w);
      end
      first += 32;
    end
    if (ph == 1) begin
      for (int i = 0; i < 32; i++) begin
        w.cyc = first + i; w.sel = 0; w.idx = i; w.addr = pac_addr(st, row - py, i);
        wq.push_back(w);
      end
    end
    d.cyc = t0 + ((gh + ph == 2) ? 67 : (gh + ph == 1) ? 35 : 2);
    d.gh = gh; d.ph = ph; d.gx = gx; d.px = px;
    dq.push_back(d);
  endtask

  task automatic drive(input int row, input int px, input int py,
                       input int gx, input int gy, input int st);
    next_row = 9'(row); PacX = 10'(px); PacY = 9'(py);
    GhostX = 10'(gx); GhostY = 9'(gy); state = 2'(st);
  endtask

  task automatic run_txn(input int row, input int px, input int py, input int gx,
                         input int gy, input int st, input bit ovr);
    int t0;
    @(posedge clk); #1;
    t0 = cyc;
    push_exp(t0, row, px, py, gx, gy, st);
    drive(row, px, py, gx, gy, st);
    line_start = 1'b1;
    @(negedge clk);
    chk("overrun_idle", int'(overrun), 0);
    @(posedge clk); #1;
    line_start = 1'b0;
    drive($urandom_range(0, 479), $urandom_range(0, 639), $urandom_range(0, 479),
          $urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 3));
    if (ovr) begin
      repeat (19) @(posedge clk);
      #1;
      drive(10, 5, 0, 6, 0, 2);
      line_start = 1'b1;
      @(negedge clk);
      chk("overrun_pulse", int'(overrun), 1);
      chk("overrun_cycle", cyc - t0, 20);
      @(posedge clk); #1;
      line_start = 1'b0;
    end
    for (int k = 0; k < 120 && dq.size() > 0; k++) @(posedge clk);
    if (dq.size() > 0) begin
      chk("done_timeout", 0, 1);
      dq.delete();
    end
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    chk("writes_left", wq.size(), 0);
    wq.delete();
    repeat (2) @(posedge clk);
  endtask

  function automatic int near_y(input int row);
    int y;
    if ($urandom_range(0, 3) == 0) return $urandom_range(0, 479);
    y = row + 2 - int'($urandom_range(0, 35));
    if (y < 0) y = 0;
    if (y > 479) y = 479;
    return y;
  endfunction

  initial begin
    int t0, row;
    rst = 1'b1;
    line_start = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_lb_we", int'(lb_we), 0);
    chk("rst_lb_sel", int'(lb_sel), 0);
    chk("rst_lb_idx", int'(lb_idx), 0);
    chk("rst_hits", int'({ghost_hit, pac_hit}), 0);
    chk("rst_xs", int'({ghost_x, pac_x}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_overrun", int'(overrun), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_txn(105, 300, 90, 200, 100, 2, 1'b0);
    run_txn(90, 11, 90, 400, 300, 1, 1'b0);
    run_txn(90, 12, 90, 400, 300, 3, 1'b0);
    run_txn(81, 13, 50, 401, 300, 0, 1'b0);
    run_txn(81, 14, 300, 402, 50, 2, 1'b0);
    run_txn(82, 15, 50, 403, 50, 1, 1'b0);
    run_txn(49, 16, 50, 404, 50, 3, 1'b0);
    run_txn(479, 17, 470, 405, 470, 0, 1'b0);
    run_txn(0, 18, 200, 406, 200, 2, 1'b0);
    run_txn(105, 300, 90, 200, 100, 2, 1'b1);

    for (int n = 0; n < 30; n++) begin
      row = $urandom_range(0, 479);
      run_txn(row, $urandom_range(0, 639), near_y(row), $urandom_range(0, 639),
              near_y(row), $urandom_range(0, 3), 1'b0);
    end

    // Reset in the middle of a both-hit fetch
    @(posedge clk); #1;
    t0 = cyc;
    push_exp(t0, 105, 300, 90, 200, 100, 2);
    drive(105, 300, 90, 200, 100, 2);
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_cycle", cyc - t0, 10);
    chk("midrst_lb_we", int'(lb_we), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_hits", int'({ghost_hit, pac_hit}), 0);
    wq.delete();
    dq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("midrst_idle", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

endmodule
